// File: rtl/qoa_spi_master_pkg.sv
// Shared definitions for the QOA SPI master: FSM state encodings, byte width
// and a sizing helper for the phase counter.
package qoa_spi_master_pkg;

   localparam int SPI_BYTE_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_TAIL  = 3'd5,
      ST_GAP   = 3'd6
   } spi_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/qoa_spi_phase_timer.sv
// Loadable down-counter timing one SPI phase; done is high in the last cycle
// of the phase (the loaded value is the phase length minus one).
module qoa_spi_phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_r;

   // Remaining cycles after the current one; stops at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {W{1'b0}}) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/qoa_spi_master.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) with CS-framed bursts.
// SCLK is derived from clk, so MISO is sampled directly on the rising-SCLK edge.
module qoa_spi_master #(
   parameter int CLK_DIV      = 4,
   parameter int CS_SETUP_CYC = 2,
   parameter int CS_IDLE_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_cs_n,
   output logic       spi_mosi,
   input  logic       spi_miso
);
   import qoa_spi_master_pkg::*;

   localparam int PW = $clog2(max3(CLK_DIV, CS_SETUP_CYC, CS_IDLE_CYC)) + 1;
   localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

   spi_state_t state_r, state_s;

   logic          tmr_load_s;
   logic [PW-1:0] tmr_val_s;
   logic          tmr_done_s;
   logic          accept_s;

   // MSB goes straight to mosi at accept, so only the remaining bits are kept
   logic [SPI_BYTE_BITS-2:0] tx_sr_r, tx_sr_s;
   logic [SPI_BYTE_BITS-1:0] rx_sr_r, rx_sr_s;
   logic [SPI_BYTE_BITS-1:0] rx_data_r, rx_data_s;
   logic [2:0] bit_cnt_r, bit_cnt_s;
   logic last_r, last_s;
   logic sclk_r, sclk_s;
   logic cs_n_r, cs_n_s;
   logic mosi_r, mosi_s;
   logic rx_valid_r, rx_valid_s;
   logic busy_r, busy_s;
   logic tx_ready_r, tx_ready_s;

   assign tx_ready = tx_ready_r & ~rst;
   assign accept_s = tx_valid & tx_ready;

   qoa_spi_phase_timer #(.W(PW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .done     (tmr_done_s)
   );

   // Every state change restarts the timer with the new phase length
   assign tmr_load_s = (state_s != state_r);

   // Phase length (minus one) of the state being entered
   always_comb begin
      case (state_s)
         ST_SETUP:                 tmr_val_s = PW'(CS_SETUP_CYC - 1);
         ST_LOW, ST_HIGH, ST_TAIL: tmr_val_s = PW'(CLK_DIV - 1);
         ST_GAP:                   tmr_val_s = PW'(CS_IDLE_CYC - 1);
         default:                  tmr_val_s = {PW{1'b0}};
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = accept_s   ? ST_SETUP : ST_IDLE;
         ST_SETUP: state_s = tmr_done_s ? ST_LOW   : ST_SETUP;
         ST_LOW:   state_s = tmr_done_s ? ST_HIGH  : ST_LOW;
         ST_HIGH: begin
            if (!tmr_done_s) begin
               state_s = ST_HIGH;
            end else if (bit_cnt_r != LAST_BIT) begin
               state_s = ST_LOW;
            end else begin
               state_s = last_r ? ST_TAIL : ST_HOLD;
            end
         end
         ST_HOLD:  state_s = accept_s   ? ST_LOW  : ST_HOLD;
         ST_TAIL:  state_s = tmr_done_s ? ST_GAP  : ST_TAIL;
         ST_GAP:   state_s = tmr_done_s ? ST_IDLE : ST_GAP;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Next values of the shifters, counters and registered outputs
   always_comb begin
      tx_sr_s    = tx_sr_r;
      rx_sr_s    = rx_sr_r;
      rx_data_s  = rx_data_r;
      bit_cnt_s  = bit_cnt_r;
      last_s     = last_r;
      sclk_s     = sclk_r;
      cs_n_s     = cs_n_r;
      mosi_s     = mosi_r;
      rx_valid_s = 1'b0;
      busy_s     = (state_s != ST_IDLE);
      tx_ready_s = (state_s == ST_IDLE) || (state_s == ST_HOLD);
      case (state_r)
         ST_IDLE, ST_HOLD: begin
            if (accept_s) begin
               tx_sr_s   = tx_data[SPI_BYTE_BITS-2:0];
               mosi_s    = tx_data[SPI_BYTE_BITS-1];
               last_s    = tx_last;
               bit_cnt_s = 3'd0;
               cs_n_s    = 1'b0;
            end else begin
               cs_n_s = cs_n_r;
            end
         end
         ST_LOW: begin
            if (tmr_done_s) begin
               sclk_s  = 1'b1;
               rx_sr_s = {rx_sr_r[SPI_BYTE_BITS-2:0], spi_miso};
            end else begin
               sclk_s = sclk_r;
            end
         end
         ST_HIGH: begin
            if (tmr_done_s) begin
               sclk_s = 1'b0;
               if (bit_cnt_r != LAST_BIT) begin
                  mosi_s    = tx_sr_r[SPI_BYTE_BITS-2];
                  tx_sr_s   = {tx_sr_r[SPI_BYTE_BITS-3:0], 1'b0};
                  bit_cnt_s = bit_cnt_r + 3'd1;
               end else begin
                  rx_data_s  = rx_sr_r;
                  rx_valid_s = 1'b1;
               end
            end else begin
               sclk_s = sclk_r;
            end
         end
         ST_TAIL: begin
            if (tmr_done_s) begin
               cs_n_s = 1'b1;
               mosi_s = 1'b0;
            end else begin
               cs_n_s = cs_n_r;
            end
         end
         ST_SETUP, ST_GAP: begin
            cs_n_s = cs_n_r;
         end
         default: begin
            cs_n_s = 1'b1;
            sclk_s = 1'b0;
            mosi_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr_r    <= {(SPI_BYTE_BITS-1){1'b0}};
         rx_sr_r    <= {SPI_BYTE_BITS{1'b0}};
         rx_data_r  <= {SPI_BYTE_BITS{1'b0}};
         bit_cnt_r  <= 3'd0;
         last_r     <= 1'b0;
         sclk_r     <= 1'b0;
         cs_n_r     <= 1'b1;
         mosi_r     <= 1'b0;
         rx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         tx_ready_r <= 1'b1;
      end else begin
         tx_sr_r    <= tx_sr_s;
         rx_sr_r    <= rx_sr_s;
         rx_data_r  <= rx_data_s;
         bit_cnt_r  <= bit_cnt_s;
         last_r     <= last_s;
         sclk_r     <= sclk_s;
         cs_n_r     <= cs_n_s;
         mosi_r     <= mosi_s;
         rx_valid_r <= rx_valid_s;
         busy_r     <= busy_s;
         tx_ready_r <= tx_ready_s;
      end
   end

   assign rx_valid = rx_valid_r;
   assign rx_data  = rx_data_r;
   assign busy     = busy_r;
   assign spi_sclk = sclk_r;
   assign spi_cs_n = cs_n_r;
   assign spi_mosi = mosi_r;

endmodule

// File: tb/tb_qoa_spi_master.sv
// Directed bench for qoa_spi_master: table of bytes with a mode-0 slave model,
// plus hand-written sequences for reset, HOLD, input churn and CLK_DIV=1 framing.
module tb_qoa_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       tx_valid, tx_last, tx_ready, rx_valid, busy, sclk, cs_n, mosi;
   logic       miso = 1'b0;
   logic [7:0] tx_data, rx_data;

   logic       tx_valid1, tx_last1, tx_ready1, rx_valid1, busy1, sclk1, cs_n1, mosi1, miso1;
   logic [7:0] tx_data1, rx_data1;

   qoa_spi_master #(.CLK_DIV(2), .CS_SETUP_CYC(2), .CS_IDLE_CYC(2)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
      .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso));

   qoa_spi_master #(.CLK_DIV(1), .CS_SETUP_CYC(2), .CS_IDLE_CYC(2)) dut1 (
      .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
      .tx_last(tx_last1), .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
      .spi_sclk(sclk1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(miso1));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mode-0 slave: MISO valid from CS fall, shifted on SCLK fall; MOSI sampled on rise
   logic [7:0] reply_q[$];
   logic [7:0] seen_q[$];
   logic [7:0] s_tx_sr = 8'h00, s_rx_sr = 8'h00, s_drop;
   logic       p_cs_n = 1'b1, p_sclk = 1'b0;
   int         s_bits = 0, rise_cnt = 0;
   always @(cs_n or sclk) begin
      if (p_cs_n === 1'b1 && cs_n === 1'b0) begin
         s_tx_sr = (reply_q.size() != 0) ? reply_q[0] : 8'h00;
         miso    = s_tx_sr[7];
         s_bits  = 0;
      end
      if (p_cs_n === 1'b0 && cs_n === 1'b1) s_bits = 0;
      if (p_sclk === 1'b0 && sclk === 1'b1) begin
         s_rx_sr = {s_rx_sr[6:0], mosi};
         s_bits++;
         rise_cnt++;
         if (s_bits == 8) begin
            seen_q.push_back(s_rx_sr);
            if (reply_q.size() != 0) s_drop = reply_q.pop_front();
            s_bits = 0;
         end
      end
      if (p_sclk === 1'b1 && sclk === 1'b0) begin
         if (s_bits == 0) begin
            s_tx_sr = (reply_q.size() != 0) ? reply_q[0] : 8'h00;
         end else begin
            s_tx_sr = {s_tx_sr[6:0], 1'b0};
         end
         miso = s_tx_sr[7];
      end
      p_cs_n = cs_n;
      p_sclk = sclk;
   end

   logic [7:0] rxd_q[$];
   int rxv_cnt = 0, cs_run = 0, last_low = 0;
   always @(posedge clk) begin
      if (rx_valid === 1'b1) begin
         rxv_cnt++;
         rxd_q.push_back(rx_data);
      end
      if (cs_n === 1'b0) cs_run++;
      else if (cs_run != 0) begin
         last_low = cs_run;
         cs_run   = 0;
      end
   end

   // CLK_DIV=1 instance monitors
   int rxv_cnt1 = 0, cs_run1 = 0, last_low1 = 0, hi_run1 = 0, last_high1 = 0;
   int rise_bits1 = 0, min_per1 = 1000, max_per1 = 0, per1;
   logic [7:0] last_rx1 = 8'h00, s1_sr = 8'h00;
   logic [7:0] seen1_q[$];
   time prev_rise1 = 0;
   always @(posedge clk) begin
      if (rx_valid1 === 1'b1) begin
         rxv_cnt1++;
         last_rx1 = rx_data1;
      end
      if (cs_n1 === 1'b0) begin
         cs_run1++;
         if (hi_run1 != 0) begin
            last_high1 = hi_run1;
            hi_run1    = 0;
         end
      end else begin
         hi_run1++;
         if (cs_run1 != 0) begin
            last_low1 = cs_run1;
            cs_run1   = 0;
         end
      end
   end
   always @(posedge sclk1) begin
      if (rise_bits1 != 0) begin
         per1 = int'(($time - prev_rise1) / 10);
         if (per1 < min_per1) min_per1 = per1;
         if (per1 > max_per1) max_per1 = per1;
      end
      prev_rise1 = $time;
      s1_sr = {s1_sr[6:0], mosi1};
      rise_bits1++;
      if (rise_bits1 == 8) begin
         seen1_q.push_back(s1_sr);
         rise_bits1 = 0;
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      int k;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      k = 0;
      while (!tx_ready && k < 500) begin
         tick();
         k++;
      end
      if (!tx_ready) check("accept timeout", 32'(tx_ready), 32'd1);
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 2000) begin
         tick();
         k++;
      end
      if (busy) check("idle timeout", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [7:0] reply;
      int         rise_dly;
      int         cs_low;
      int         rises;
   } vec_t;
   vec_t vecs[4];

   int dly, n, bad, base_rise, base_rx, frame_rises, acc;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 8'h3C, 4, 36, 8};
      vecs[1] = '{8'h01, 1'b0, 8'h5A, 4, 0, 0};
      vecs[2] = '{8'h80, 1'b0, 8'hC3, 2, 0, 0};
      vecs[3] = '{8'hFF, 1'b1, 8'h00, 2, 102, 24};

      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
      tx_valid1 = 1'b0; tx_data1 = 8'hB4; tx_last1 = 1'b1; miso1 = 1'b1;
      frame_rises = 0;
      repeat (3) tick();
      check("reset tx_ready", 32'(tx_ready), 32'd0);
      check("reset cs_n", 32'(cs_n), 32'd1);
      check("reset sclk", 32'(sclk), 32'd0);
      check("reset mosi", 32'(mosi), 32'd0);
      check("reset rx_valid", 32'(rx_valid), 32'd0);
      check("reset rx_data", 32'(rx_data), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();
      check("idle tx_ready", 32'(tx_ready), 32'd1);

      // Single frame 0xA5 then 3-byte burst with tx_valid re-offered at once
      for (int i = 0; i < 4; i++) begin
         if (!busy) frame_rises = rise_cnt;
         reply_q.push_back(vecs[i].reply);
         send(vecs[i].data, vecs[i].last);
         dly = 0;
         while (!sclk && dly < 100) begin
            tick();
            dly++;
         end
         check($sformatf("v%0d first rise delay", i), 32'(dly), 32'(vecs[i].rise_dly));
         if (vecs[i].last) begin
            wait_idle();
            check($sformatf("v%0d cs_n low cycles", i), 32'(last_low), 32'(vecs[i].cs_low));
            check($sformatf("v%0d sclk rises", i), 32'(rise_cnt - frame_rises), 32'(vecs[i].rises));
         end
      end
      check("table rx_valid count", 32'(rxv_cnt), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < rxd_q.size()) check($sformatf("v%0d rx_data", i), 32'(rxd_q[i]), 32'(vecs[i].reply));
         else check($sformatf("v%0d rx missing", i), 32'(rxd_q.size()), 32'(i + 1));
         if (i < seen_q.size()) check($sformatf("v%0d slave saw", i), 32'(seen_q[i]), 32'(vecs[i].data));
         else check($sformatf("v%0d slave missing", i), 32'(seen_q.size()), 32'(i + 1));
      end

      // Churn tx_data/tx_valid while the byte is in flight
      base_rise = rise_cnt;
      base_rx   = rxv_cnt;
      reply_q.push_back(8'h99);
      send(8'h6E, 1'b1);
      for (int k = 0; k < 200; k++) begin
         if (tx_ready) begin
            tx_valid = 1'b0;
            break;
         end
         tx_valid = ~tx_valid;
         tx_data  = 8'($urandom);
         tx_last  = 1'($urandom);
         tick();
      end
      tx_valid = 1'b0;
      wait_idle();
      check("churn rises", 32'(rise_cnt - base_rise), 32'd8);
      check("churn rx count", 32'(rxv_cnt - base_rx), 32'd1);
      check("churn slave saw", 32'(seen_q[$]), 32'h6E);
      check("churn rx_data", 32'(rxd_q[$]), 32'h99);

      // Reset during the 4th high phase of 0xDB
      reply_q.push_back(8'h77);
      base_rise = rise_cnt;
      base_rx   = rxv_cnt;
      send(8'hDB, 1'b1);
      n = 0;
      while (rise_cnt < base_rise + 4 && n < 200) begin
         tick();
         n++;
      end
      check("abort reached 4th rise", 32'(rise_cnt - base_rise), 32'd4);
      rst = 1'b1;
      tick();
      check("abort cs_n", 32'(cs_n), 32'd1);
      check("abort sclk", 32'(sclk), 32'd0);
      check("abort mosi", 32'(mosi), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort rx_valid", 32'(rx_valid), 32'd0);
      check("abort rx_data", 32'(rx_data), 32'd0);
      check("abort tx_ready", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      repeat (4) tick();
      check("abort no rx_valid", 32'(rxv_cnt - base_rx), 32'd0);
      reply_q.delete();
      reply_q.push_back(8'h2D);
      send(8'h55, 1'b1);
      wait_idle();
      check("post-abort slave saw", 32'(seen_q[$]), 32'h55);
      check("post-abort rx_data", 32'(rxd_q[$]), 32'h2D);
      check("post-abort rx count", 32'(rxv_cnt - base_rx), 32'd1);

      // Park in HOLD for 100 cycles, then finish the frame
      reply_q.push_back(8'hE7);
      reply_q.push_back(8'h18);
      send(8'h12, 1'b0);
      n = 0;
      while (!tx_ready && n < 200) begin
         tick();
         n++;
      end
      check("hold reached", 32'(tx_ready), 32'd1);
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         if (cs_n !== 1'b0 || sclk !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) bad++;
         tick();
      end
      check("hold steady cycles bad", 32'(bad), 32'd0);
      send(8'h34, 1'b1);
      dly = 0;
      while (!sclk && dly < 100) begin
         tick();
         dly++;
      end
      check("hold first rise delay", 32'(dly), 32'd2);
      wait_idle();
      check("hold cs_n low cycles", 32'(last_low), 32'd169);
      check("hold slave saw 1st", 32'(seen_q[$-1]), 32'h12);
      check("hold slave saw 2nd", 32'(seen_q[$]), 32'h34);
      check("hold rx 1st", 32'(rxd_q[$-1]), 32'hE7);
      check("hold rx 2nd", 32'(rxd_q[$]), 32'h18);
      check("hold rx_data held", 32'(rx_data), 32'h18);

      // CLK_DIV=1: two single-byte frames back-to-back
      tx_valid1 = 1'b1;
      acc = 0;
      for (int k = 0; k < 300 && acc < 2; k++) begin
         if (tx_ready1) acc++;
         tick();
      end
      tx_valid1 = 1'b0;
      n = 0;
      while (busy1 && n < 300) begin
         tick();
         n++;
      end
      check("div1 accepts", 32'(acc), 32'd2);
      check("div1 idle", 32'(busy1), 32'd0);
      check("div1 cs_n low cycles", 32'(last_low1), 32'd19);
      check("div1 cs_n gap >= idle", 32'(last_high1 >= 2), 32'd1);
      check("div1 min sclk period", 32'(min_per1), 32'd2);
      check("div1 max sclk period", 32'(max_per1), 32'd2);
      check("div1 rx count", 32'(rxv_cnt1), 32'd2);
      check("div1 rx_data", 32'(last_rx1), 32'hFF);
      check("div1 bytes seen", 32'(seen1_q.size()), 32'd2);
      if (seen1_q.size() == 2) begin
         check("div1 byte0", 32'(seen1_q[0]), 32'hB4);
         check("div1 byte1", 32'(seen1_q[1]), 32'hB4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
